bullet_controller: RTL and testbench
====================================

BULLET_CONTROLLER -- requirements
Module: bullet_controller

Interface
REQ-001 SHALL have parameter BULLET_SPEED, default 4, pixels the bullet rises per frame tick.
REQ-002 SHALL have parameter PLAYER_Y, default 440, screen row of the player sprite top.
REQ-003 SHALL have parameter PLAYER_HALF_W, default 16, horizontal offset from playerX to the muzzle column.
REQ-004 SHALL have parameter TOP_Y, default 0, topmost row the bullet may reach.
REQ-005 SHALL have parameter COOLDOWN_FRAMES, default 8, frame ticks of refire lockout (used only when BULLET_COOLDOWN_EN is defined).
REQ-006 SHALL have port Clk  input  1  system clock; all state on rising edge.
REQ-007 SHALL have port Reset_N  input  1  reset, asynchronous, active-low.
REQ-008 SHALL have port frame_clk  input  1  frame strobe from the VGA controller, synchronous to Clk.
REQ-009 SHALL have port fire  input  1  fire key level, synchronous to Clk.
REQ-010 SHALL have port playerX  input  10  player sprite left column.
REQ-011 SHALL have port hit  input  1  collision flag from enemy logic, level-sampled.
REQ-012 SHALL have port bullet_in  output  1  bullet visible, to color mapper.
REQ-013 SHALL have port bulletX  output  10  bullet column, to color mapper.
REQ-014 SHALL have port bulletY  output  10  bullet top row (bullet occupies bulletY..bulletY+3).
REQ-015 SHALL have port hit_ack  output  1  one-cycle pulse when a flight ends by hit.
REQ-016 SHALL have port shots_fired  output  8  count of launched bullets.

Function
REQ-017 SHALL derive frame tick = frame_clk high this cycle and low in the previous cycle (one-register edge detect).
REQ-018 SHALL derive fire_rise the same way from fire; a held fire key SHALL launch at most one bullet.
REQ-019 SHALL implement states IDLE, FLIGHT, COOLDOWN; bullet_in SHALL be 1 exactly when state is FLIGHT.
REQ-020 In IDLE, fire_rise SHALL load bulletX = (playerX + PLAYER_HALF_W) truncated to 10 bits, load bulletY = PLAYER_Y - 4, increment shots_fired (wraps 255->0), and enter FLIGHT; bullet_in rises the next cycle.
REQ-021 In FLIGHT, fire_rise SHALL be ignored and not queued.
REQ-022 In FLIGHT, on a frame tick with bulletY >= TOP_Y + BULLET_SPEED, bulletY SHALL decrease by BULLET_SPEED; otherwise the flight SHALL end (no underflow).
REQ-023 In FLIGHT, hit=1 SHALL end the flight in that cycle and assert hit_ack for exactly one cycle; hit SHALL take priority over a simultaneous frame tick.
REQ-024 hit SHALL be ignored outside FLIGHT; hit_ack SHALL remain 0 for top-of-screen endings.
REQ-025 On flight end, bulletX/bulletY SHALL hold their last values and bullet_in SHALL fall the next cycle.
REQ-026 bulletX SHALL NOT track playerX after launch.

Reset
REQ-027 Reset_N=0 SHALL asynchronously force state IDLE, bullet_in=0, bulletX=0, bulletY=0, hit_ack=0, shots_fired=0, cooldown counter=0, edge-detect registers=0.
REQ-028 Reset during FLIGHT or COOLDOWN SHALL remove the bullet immediately; the first fire_rise after release SHALL launch normally.

Configuration
REQ-029 With macro BULLET_COOLDOWN_EN defined, flight end SHALL enter COOLDOWN, load the counter with COOLDOWN_FRAMES, decrement per frame tick, ignore fire_rise, and return to IDLE when a tick occurs with counter=1.
REQ-030 Without BULLET_COOLDOWN_EN, flight end SHALL go directly to IDLE, COOLDOWN SHALL be unreachable, and the counter SHALL not exist.

Verification
REQ-031 playerX=100, fire pulse in IDLE -> next cycle bullet_in=1, bulletX=116, bulletY=436, shots_fired=1.
REQ-032 Launch, then 3 frame ticks -> bulletY=424; fire held high throughout -> shots_fired stays 1.
REQ-033 bulletY=2, frame tick -> bullet_in=0 next cycle, bulletY holds 2, hit_ack=0.
REQ-034 FLIGHT, hit and frame tick in the same cycle -> bulletY unchanged, hit_ack=1 for one cycle, bullet_in=0 next cycle.
REQ-035 BULLET_COOLDOWN_EN, COOLDOWN_FRAMES=8: fire_rise at 3 ticks after hit -> no launch; fire_rise after 8th tick -> launch.
REQ-036 Reset_N low mid-flight -> bullet_in=0, bulletX=0, bulletY=0, shots_fired=0 without a Clk edge.

Source files
------------

// File: rtl/bullet_controller.sv
// bullet_controller: single player bullet for a VGA shooter.
// Launches a bullet from the player's muzzle on a fire-key rising edge, moves
// it up BULLET_SPEED rows per frame tick, and ends the flight on a hit or when
// the next step would pass TOP_Y.
// Optional feature macro: BULLET_COOLDOWN_EN (refire lockout of COOLDOWN_FRAMES
// frame ticks after every flight end). Default build: feature disabled.
module bullet_controller #(
    parameter int BULLET_SPEED    = 4,
    parameter int PLAYER_Y        = 440,
    parameter int PLAYER_HALF_W   = 16,
    parameter int TOP_Y           = 0,
    parameter int COOLDOWN_FRAMES = 8
) (
    input  logic       Clk,
    input  logic       Reset_N,
    input  logic       frame_clk,
    input  logic       fire,
    input  logic [9:0] playerX,
    input  logic       hit,
    output logic       bullet_in,
    output logic [9:0] bulletX,
    output logic [9:0] bulletY,
    output logic       hit_ack,
    output logic [7:0] shots_fired
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FLIGHT   = 2'd1,
        ST_COOLDOWN = 2'd2
    } state_e;

    localparam logic [9:0]  SPEED_C    = 10'(BULLET_SPEED);
    localparam logic [9:0]  HALF_W_C   = 10'(PLAYER_HALF_W);
    localparam logic [9:0]  LAUNCH_Y_C = 10'(PLAYER_Y - 4);
    // One extra bit so TOP_Y + BULLET_SPEED cannot wrap in the comparison.
    localparam logic [10:0] FLOOR_C    = 11'(TOP_Y + BULLET_SPEED);

    // Reject configurations the counter/arithmetic cannot represent.
    if (COOLDOWN_FRAMES < 1 || COOLDOWN_FRAMES > 255 || BULLET_SPEED < 1) begin : g_bad_cfg
        $error("bullet_controller: unsupported parameter value");
    end

    state_e     state_q, state_d;
    logic [9:0] bullet_x_q, bullet_x_d;
    logic [9:0] bullet_y_q, bullet_y_d;
    logic       hit_ack_q, hit_ack_d;
    logic [7:0] shots_q, shots_d;
    logic       frame_prev_q;
    logic       fire_prev_q;
    logic       frame_tick_s;
    logic       fire_rise_s;
    logic       flight_end_s;
`ifdef BULLET_COOLDOWN_EN
    logic [7:0] cool_cnt_q, cool_cnt_d;
`endif

    // Single-register edge detectors; both inputs are already in the Clk domain.
    assign frame_tick_s = frame_clk & ~frame_prev_q;
    assign fire_rise_s  = fire & ~fire_prev_q;

    // Next-state and datapath decisions for the bullet FSM.
    always_comb begin
        state_d      = state_q;
        bullet_x_d   = bullet_x_q;
        bullet_y_d   = bullet_y_q;
        hit_ack_d    = 1'b0;
        shots_d      = shots_q;
        flight_end_s = 1'b0;
`ifdef BULLET_COOLDOWN_EN
        cool_cnt_d   = cool_cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (fire_rise_s) begin
                    // Muzzle column is latched once; the bullet does not follow the player.
                    bullet_x_d = playerX + HALF_W_C;
                    bullet_y_d = LAUNCH_Y_C;
                    shots_d    = shots_q + 8'd1;
                    state_d    = ST_FLIGHT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FLIGHT: begin
                // Hit wins over a simultaneous frame tick; fire is ignored here.
                if (hit) begin
                    hit_ack_d    = 1'b1;
                    flight_end_s = 1'b1;
                end else if (frame_tick_s) begin
                    if ({1'b0, bullet_y_q} >= FLOOR_C) begin
                        bullet_y_d = bullet_y_q - SPEED_C;
                    end else begin
                        flight_end_s = 1'b1;
                    end
                end else begin
                    flight_end_s = 1'b0;
                end
                if (flight_end_s) begin
`ifdef BULLET_COOLDOWN_EN
                    state_d    = ST_COOLDOWN;
                    cool_cnt_d = 8'(COOLDOWN_FRAMES);
`else
                    state_d    = ST_IDLE;
`endif
                end else begin
                    state_d = ST_FLIGHT;
                end
            end
            ST_COOLDOWN: begin
`ifdef BULLET_COOLDOWN_EN
                if (frame_tick_s) begin
                    if (cool_cnt_q <= 8'd1) begin
                        cool_cnt_d = 8'd0;
                        state_d    = ST_IDLE;
                    end else begin
                        cool_cnt_d = cool_cnt_q - 8'd1;
                    end
                end else begin
                    cool_cnt_d = cool_cnt_q;
                end
`else
                // Unreachable without the cooldown feature; recover to IDLE.
                state_d = ST_IDLE;
`endif
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, datapath and edge-detect registers with asynchronous clear.
    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            state_q      <= ST_IDLE;
            bullet_x_q   <= 10'd0;
            bullet_y_q   <= 10'd0;
            hit_ack_q    <= 1'b0;
            shots_q      <= 8'd0;
            frame_prev_q <= 1'b0;
            fire_prev_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            bullet_x_q   <= bullet_x_d;
            bullet_y_q   <= bullet_y_d;
            hit_ack_q    <= hit_ack_d;
            shots_q      <= shots_d;
            frame_prev_q <= frame_clk;
            fire_prev_q  <= fire;
        end
    end

`ifdef BULLET_COOLDOWN_EN
    // Refire lockout counter.
    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            cool_cnt_q <= 8'd0;
        end else begin
            cool_cnt_q <= cool_cnt_d;
        end
    end
`endif

    assign bullet_in   = (state_q == ST_FLIGHT);
    assign bulletX     = bullet_x_q;
    assign bulletY     = bullet_y_q;
    assign hit_ack     = hit_ack_q;
    assign shots_fired = shots_q;

endmodule

// File: tb/tb_bullet_controller.sv
// Directed self-checking bench for bullet_controller (default parameters on
// u_dut; a second instance with PLAYER_Y=10 exercises the top-of-screen end).
module tb_bullet_controller;

    logic       Clk;
    logic       Reset_N;
    logic       frame_clk;
    logic       fire;
    logic [9:0] playerX;
    logic       hit;

    logic       bullet_in;
    logic [9:0] bulletX;
    logic [9:0] bulletY;
    logic       hit_ack;
    logic [7:0] shots_fired;

    logic       t_bullet_in;
    logic [9:0] t_bulletX;
    logic [9:0] t_bulletY;
    logic       t_hit_ack;
    logic [7:0] t_shots_fired;

    int n_checks = 0;
    int n_pass   = 0;

    bullet_controller u_dut (
        .Clk        (Clk),
        .Reset_N    (Reset_N),
        .frame_clk  (frame_clk),
        .fire       (fire),
        .playerX    (playerX),
        .hit        (hit),
        .bullet_in  (bullet_in),
        .bulletX    (bulletX),
        .bulletY    (bulletY),
        .hit_ack    (hit_ack),
        .shots_fired(shots_fired)
    );

    bullet_controller #(.PLAYER_Y(10)) u_dut_top (
        .Clk        (Clk),
        .Reset_N    (Reset_N),
        .frame_clk  (frame_clk),
        .fire       (fire),
        .playerX    (playerX),
        .hit        (hit),
        .bullet_in  (t_bullet_in),
        .bulletX    (t_bulletX),
        .bulletY    (t_bulletY),
        .hit_ack    (t_hit_ack),
        .shots_fired(t_shots_fired)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic frame_tick();
        frame_clk = 1'b1;
        step();
        frame_clk = 1'b0;
        step();
    endtask

    // Launch a bullet and end its flight with a hit.
    task automatic shoot_and_hit();
        fire = 1'b0;
        step();
        fire = 1'b1;
        step();
        hit = 1'b1;
        step();
        hit = 1'b0;
        step();
    endtask

    initial begin
        Reset_N   = 1'b1;
        frame_clk = 1'b0;
        fire      = 1'b0;
        playerX   = 10'd100;
        hit       = 1'b0;

        // Reset state
        #1 Reset_N = 1'b0;
        #2;
        check("rst_bullet_in", int'(bullet_in), 0);
        check("rst_bulletX", int'(bulletX), 0);
        check("rst_bulletY", int'(bulletY), 0);
        check("rst_hit_ack", int'(hit_ack), 0);
        check("rst_shots", int'(shots_fired), 0);
        #4 Reset_N = 1'b1;
        step();
        step();

        // Launch from playerX=100
        fire = 1'b1;
        step();
        check("launch_bullet_in", int'(bullet_in), 1);
        check("launch_bulletX", int'(bulletX), 116);
        check("launch_bulletY", int'(bulletY), 436);
        check("launch_shots", int'(shots_fired), 1);
        check("top_launch_bulletY", int'(t_bulletY), 6);

        // Three frame ticks with fire held; player moves but bullet column stays
        playerX = 10'd200;
        frame_tick();
        check("top_tick1_bulletY", int'(t_bulletY), 2);
        frame_tick();
        check("top_end_bullet_in", int'(t_bullet_in), 0);
        check("top_end_bulletY", int'(t_bulletY), 2);
        check("top_end_hit_ack", int'(t_hit_ack), 0);
        frame_tick();
        check("tick3_bulletY", int'(bulletY), 424);
        check("tick3_bulletX", int'(bulletX), 116);
        check("held_fire_shots", int'(shots_fired), 1);

        // New fire edge during flight is ignored
        fire = 1'b0;
        step();
        fire = 1'b1;
        step();
        check("flight_fire_shots", int'(shots_fired), 1);
        check("flight_fire_bullet_in", int'(bullet_in), 1);

        // Asynchronous reset mid-flight, between clock edges
        #2 Reset_N = 1'b0;
        fire = 1'b0;
        #1;
        check("midrst_bullet_in", int'(bullet_in), 0);
        check("midrst_bulletX", int'(bulletX), 0);
        check("midrst_bulletY", int'(bulletY), 0);
        check("midrst_shots", int'(shots_fired), 0);
        #1 Reset_N = 1'b1;
        step();

        // First fire after reset launches normally from playerX=200
        fire = 1'b1;
        step();
        check("relaunch_bullet_in", int'(bullet_in), 1);
        check("relaunch_bulletX", int'(bulletX), 216);
        check("relaunch_bulletY", int'(bulletY), 436);
        check("relaunch_shots", int'(shots_fired), 1);

        // Hit together with a frame tick: hit wins, bullet does not move
        hit       = 1'b1;
        frame_clk = 1'b1;
        step();
        check("hit_bullet_in", int'(bullet_in), 0);
        check("hit_ack_pulse", int'(hit_ack), 1);
        check("hit_bulletY", int'(bulletY), 436);
        hit       = 1'b0;
        frame_clk = 1'b0;
        step();
        check("hit_ack_one_cycle", int'(hit_ack), 0);

        // Hit outside flight is ignored
        hit = 1'b1;
        step();
        check("idle_hit_ack", int'(hit_ack), 0);
        hit = 1'b0;
        step();

`ifdef BULLET_COOLDOWN_EN
        // Cooldown: 3 ticks after the hit, a fire edge must not launch
        for (int i = 0; i < 3; i++) frame_tick();
        fire = 1'b0;
        step();
        fire = 1'b1;
        step();
        check("cool_blocked_bullet_in", int'(bullet_in), 0);
        check("cool_blocked_shots", int'(shots_fired), 1);
        // After the 8th tick the controller is ready again
        for (int i = 0; i < 5; i++) frame_tick();
        fire = 1'b0;
        step();
        fire = 1'b1;
        step();
        check("cool_done_bullet_in", int'(bullet_in), 1);
        check("cool_done_shots", int'(shots_fired), 2);
`else
        // shots_fired wraps 255 -> 0
        for (int i = 0; i < 254; i++) shoot_and_hit();
        check("shots_255", int'(shots_fired), 255);
        shoot_and_hit();
        check("shots_wrap", int'(shots_fired), 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
